// File: rtl/config_loader_if.sv
// rtl/config_loader_if.sv - serial bitstream input and config-chain output bundle
interface config_loader_if;
  logic bit_in;
  logic bit_valid;
  logic bit_ready;
  logic cfg_dout;
  logic cfg_shift_en;
  logic cfg_commit;

  modport master (
    output bit_in, bit_valid,
    input  bit_ready, cfg_dout, cfg_shift_en, cfg_commit
  );

  modport slave (
    input  bit_in, bit_valid,
    output bit_ready, cfg_dout, cfg_shift_en, cfg_commit
  );
endinterface

// File: rtl/config_loader.sv
// rtl/config_loader.sv - framed serial config loader: sync word, payload, even parity, commit
module config_loader #(
  parameter logic [7:0] SYNC_WORD = 8'hA5,
  parameter int TILE_BITS = 33,
  parameter int NUM_TILES = 14,
  parameter int SB_BITS   = 16,
  parameter int NUM_SB    = 22,
  parameter int TOTAL_BITS = TILE_BITS * NUM_TILES + SB_BITS * NUM_SB,
  parameter int CNT_W     = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  config_loader_if.slave     bus,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [CNT_W-1:0]   bit_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_LOAD, S_CHECK, S_COMMIT, S_DONE, S_ERROR
  } state_t;

  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL_BITS);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(TOTAL_BITS - 1);

  state_t           state_q, state_d;
  logic [7:0]       sync_q, sync_d;
  logic [3:0]       sync_cnt_q, sync_cnt_d;
  logic             parity_q, parity_d;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;
  logic             cfg_dout_q, cfg_dout_d;
  logic             cfg_shift_en_q, cfg_shift_en_d;
  logic             accept;
  logic [7:0]       sync_next;

  assign bus.bit_ready = (state_q == S_SYNC) || (state_q == S_LOAD) || (state_q == S_CHECK);
  assign accept        = bus.bit_valid && bus.bit_ready;
  assign sync_next     = {sync_q[6:0], bus.bit_in};

  always_comb begin
    state_d        = state_q;
    sync_d         = sync_q;
    sync_cnt_d     = sync_cnt_q;
    parity_d       = parity_q;
    bit_count_d    = bit_count_q;
    cfg_dout_d     = cfg_dout_q;
    cfg_shift_en_d = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        // Every restart begins from a clean frame, whatever ended the last one.
        if (start) begin
          state_d     = S_SYNC;
          sync_d      = 8'h00;
          sync_cnt_d  = 4'd0;
          parity_d    = 1'b0;
          bit_count_d = '0;
        end
      end
      S_SYNC: begin
        if (accept) begin
          sync_d     = sync_next;
          sync_cnt_d = sync_cnt_q + 4'd1;
          if (sync_cnt_q == 4'd7)
            state_d = (sync_next == SYNC_WORD) ? S_LOAD : S_ERROR;
        end
      end
      S_LOAD: begin
        if (accept) begin
          cfg_dout_d     = bus.bit_in;
          cfg_shift_en_d = 1'b1;
          parity_d       = parity_q ^ bus.bit_in;
          if (bit_count_q < TOTAL_C)
            bit_count_d = bit_count_q + 1'b1;
          if (bit_count_q == LAST_C)
            state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (accept)
          state_d = ((parity_q ^ bus.bit_in) == 1'b0) ? S_COMMIT : S_ERROR;
      end
      S_COMMIT: state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      sync_q         <= 8'h00;
      sync_cnt_q     <= 4'd0;
      parity_q       <= 1'b0;
      bit_count_q    <= '0;
      cfg_dout_q     <= 1'b0;
      cfg_shift_en_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync_q         <= sync_d;
      sync_cnt_q     <= sync_cnt_d;
      parity_q       <= parity_d;
      bit_count_q    <= bit_count_d;
      cfg_dout_q     <= cfg_dout_d;
      cfg_shift_en_q <= cfg_shift_en_d;
    end
  end

  assign bus.cfg_dout     = cfg_dout_q;
  assign bus.cfg_shift_en = cfg_shift_en_q;
  assign bus.cfg_commit   = (state_q == S_COMMIT);
  assign busy             = (state_q == S_SYNC) || (state_q == S_LOAD) ||
                            (state_q == S_CHECK) || (state_q == S_COMMIT);
  assign done             = (state_q == S_DONE);
  assign error            = (state_q == S_ERROR);
  assign bit_count        = bit_count_q;

endmodule

// File: tb/tb_config_loader.sv
// tb/tb_config_loader.sv - scoreboard bench for config_loader
module tb_config_loader;

  localparam int TOTAL = 814;
  localparam int CNT_W = 10;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             busy, done, error;
  logic [CNT_W-1:0] bit_count;

  config_loader_if ifc ();

  config_loader dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .bus       (ifc.slave),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .bit_count (bit_count)
  );

  always #5 clock = ~clock;

  int   n_checks = 0;
  int   n_pass   = 0;
  logic exp_q[$];
  int   shift_total  = 0;
  int   commit_total = 0;
  logic prev_acc     = 1'b0;
  logic gap_mode     = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Monitor on the falling edge: pop the scoreboard for every chain shift.
  always @(negedge clock) begin
    if (ifc.cfg_shift_en === 1'b1) begin
      shift_total++;
      check("shift_after_accept", {31'd0, prev_acc}, 32'd1);
      if (exp_q.size() == 0) check("shift_unexpected", 32'd1, 32'd0);
      else check("shift_data", {31'd0, ifc.cfg_dout}, {31'd0, exp_q.pop_front()});
    end
    if (ifc.cfg_commit === 1'b1) commit_total++;
    prev_acc = ifc.bit_valid && ifc.bit_ready && !reset;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    int t;
    t = 0;
    ifc.bit_in    = b;
    ifc.bit_valid = 1'b1;
    while (ifc.bit_ready !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) check("ready_timeout", 32'd0, 32'd1);
    tick();
    ifc.bit_valid = 1'b0;
    if (gap_mode) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_sync(input logic [7:0] sw);
    for (int i = 7; i >= 0; i--) send_bit(sw[i]);
  endtask

  // pat 0: alternating 1,0,...  pat 1: random.  Returns the running XOR.
  task automatic send_payload(input int pat, input int n, inout logic par);
    logic b;
    for (int i = 0; i < n; i++) begin
      b = (pat == 0) ? ((i % 2) == 0) : 1'($urandom);
      exp_q.push_back(b);
      par = par ^ b;
      send_bit(b);
    end
  endtask

  task automatic wait_settle(input string tag);
    int t;
    t = 0;
    while (done !== 1'b1 && error !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    if (t >= 20) check(tag, 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic good_frame(input string tag, input int pat);
    logic par;
    int   s0, c0;
    s0 = shift_total;
    c0 = commit_total;
    par = 1'b0;
    pulse_start();
    send_sync(8'hA5);
    send_payload(pat, TOTAL, par);
    send_bit(par);
    wait_settle({tag, "_timeout"});
    tick();
    check({tag, "_done"},    {31'd0, done}, 32'd1);
    check({tag, "_error"},   {31'd0, error}, 32'd0);
    check({tag, "_shifts"},  shift_total - s0, TOTAL);
    check({tag, "_commits"}, commit_total - c0, 32'd1);
    check({tag, "_count"},   {22'd0, bit_count}, TOTAL);
    check({tag, "_queue"},   exp_q.size(), 32'd0);
  endtask

  initial begin
    logic par;
    int   s0, c0;
    ifc.bit_in    = 1'b0;
    ifc.bit_valid = 1'b0;
    do_reset();

    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_ready", {31'd0, ifc.bit_ready}, 32'd0);
    check("rst_shift", {31'd0, ifc.cfg_shift_en}, 32'd0);
    check("rst_count", {22'd0, bit_count}, 32'd0);

    // 1: clean alternating frame
    good_frame("t1", 0);

    // 2: bad sync word
    do_reset();
    s0 = shift_total;
    c0 = commit_total;
    pulse_start();
    check("t2_busy", {31'd0, busy}, 32'd1);
    send_sync(8'hA4);
    check("t2_error",   {31'd0, error}, 32'd1);
    check("t2_shifts",  shift_total - s0, 32'd0);
    check("t2_commits", commit_total - c0, 32'd0);

    // 3: wrong parity, restarted straight from ERROR
    s0 = shift_total;
    c0 = commit_total;
    par = 1'b0;
    pulse_start();
    send_sync(8'hA5);
    send_payload(1, TOTAL, par);
    send_bit(~par);
    wait_settle("t3_timeout");
    tick();
    check("t3_error",   {31'd0, error}, 32'd1);
    check("t3_done",    {31'd0, done}, 32'd0);
    check("t3_shifts",  shift_total - s0, TOTAL);
    check("t3_commits", commit_total - c0, 32'd0);

    // 4: gapped bit_valid
    gap_mode = 1'b1;
    good_frame("t4", 0);
    gap_mode = 1'b0;

    // 5: reset in the middle of the payload
    c0 = commit_total;
    par = 1'b0;
    pulse_start();
    send_sync(8'hA5);
    send_payload(1, 400, par);
    check("t5_mid_count", {22'd0, bit_count}, 32'd400);
    reset = 1'b1;
    tick();
    check("t5_busy",   {31'd0, busy}, 32'd0);
    check("t5_done",   {31'd0, done}, 32'd0);
    check("t5_error",  {31'd0, error}, 32'd0);
    check("t5_ready",  {31'd0, ifc.bit_ready}, 32'd0);
    check("t5_shift",  {31'd0, ifc.cfg_shift_en}, 32'd0);
    check("t5_dout",   {31'd0, ifc.cfg_dout}, 32'd0);
    check("t5_commit", {31'd0, ifc.cfg_commit}, 32'd0);
    check("t5_count",  {22'd0, bit_count}, 32'd0);
    check("t5_queue",  exp_q.size(), 32'd0);
    reset = 1'b0;
    tick();
    check("t5_no_commit", commit_total - c0, 32'd0);
    good_frame("t5b", 1);

    // 6: start during LOAD is ignored; start in DONE restarts
    s0 = shift_total;
    c0 = commit_total;
    par = 1'b0;
    pulse_start();
    send_sync(8'hA5);
    send_payload(0, 100, par);
    start = 1'b1;
    send_payload(0, 2, par);
    start = 1'b0;
    check("t6_count_after_start", {22'd0, bit_count}, 32'd102);
    send_payload(0, TOTAL - 102, par);
    send_bit(par);
    wait_settle("t6_timeout");
    tick();
    check("t6_done",    {31'd0, done}, 32'd1);
    check("t6_shifts",  shift_total - s0, TOTAL);
    check("t6_commits", commit_total - c0, 32'd1);
    pulse_start();
    check("t6_restart_busy",  {31'd0, busy}, 32'd1);
    check("t6_restart_count", {22'd0, bit_count}, 32'd0);
    c0 = commit_total;
    par = 1'b0;
    send_sync(8'hA5);
    send_payload(1, TOTAL, par);
    send_bit(par);
    wait_settle("t6b_timeout");
    tick();
    check("t6b_done",    {31'd0, done}, 32'd1);
    check("t6b_commits", commit_total - c0, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
